// File: rtl/cache_types_pkg.sv
// ---------------------------------------------------------------------------
// cache_types_pkg
// Shared types and sizes for the cache <-> physical-memory line adaptor.
//   state_t   : adaptor control states (IDLE, READ, WRITE, DONE)
//   S_LINE    : cacheline width in bits
//   S_BURST   : memory bus width in bits per beat
//   BURST_LEN : beats per cacheline
//   S_OFFSET  : line-offset bits cleared on the outgoing address
//   COUNT_W   : width of the beat counter
// ---------------------------------------------------------------------------
package cache_types_pkg;

  localparam int S_LINE    = 256;
  localparam int S_BURST   = 64;
  localparam int BURST_LEN = S_LINE / S_BURST;
  localparam int S_OFFSET  = 5;
  localparam int COUNT_W   = $clog2(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage : cache_types_pkg

// File: rtl/cacheline_adaptor.sv
// ---------------------------------------------------------------------------
// cacheline_adaptor
// Turns single cacheline read/write requests from the cache into 4-beat
// bursts on the physical-memory bus, and hands the assembled line plus a
// one-cycle completion pulse back to the cache.
//
// Ports
//   clk        : clock
//   rst        : asynchronous reset, active low
//   line_i     : line to write, from cache (pmem_wdata)
//   line_o     : assembled read line, to cache (pmem_rdata)
//   address_i  : line address, from cache (pmem_address)
//   read_i     : line read request, from cache
//   write_i    : line write request, from cache
//   resp_o     : line transfer complete, to cache (pmem_resp)
//   burst_i    : read beat, from memory
//   burst_o    : write beat, to memory
//   address_o  : line-aligned burst address, to memory
//   read_o     : burst read request, to memory
//   write_o    : burst write request, to memory
//   resp_i     : beat valid / accepted, from memory
// ---------------------------------------------------------------------------
module cacheline_adaptor
  import cache_types_pkg::*;
#(
  parameter int s_line   = S_LINE,
  parameter int s_burst  = S_BURST,
  parameter int s_offset = S_OFFSET
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int burst_len = s_line / s_burst;
  localparam int count_w   = $clog2(burst_len);

  state_t              state;
  state_t              next_state;
  logic [count_w-1:0]  count;
  logic [s_line-1:0]   buffer;
  logic [31:0]         addr_q;
  logic                last_beat;

  // The offset bits of the cache address never reach memory; they are
  // gathered here only so lint sees them as intentionally dropped.
  logic unused_offset_bits;
  assign unused_offset_bits = ^address_i[s_offset-1:0];

  assign last_beat = (count == count_w'(burst_len - 1));

  // State register; reset drops any burst in flight without a response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A simultaneous read and write request is served as a
  // write, and memory responses seen while idle are ignored.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (write_i) begin
          next_state = WRITE;
        end else if (read_i) begin
          next_state = READ;
        end
      end
      READ, WRITE: begin
        if (resp_i && last_beat) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: the request is latched once in IDLE so later changes on the
  // cache side cannot disturb a running burst. The counter holds on the last
  // beat and is cleared only in DONE, so it never wraps mid-burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buffer <= '0;
      count  <= '0;
      addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i) begin
            buffer <= line_i;
            addr_q <= {address_i[31:s_offset], {s_offset{1'b0}}};
          end else if (read_i) begin
            addr_q <= {address_i[31:s_offset], {s_offset{1'b0}}};
          end
        end
        READ: begin
          if (resp_i) begin
            buffer[s_burst*count +: s_burst] <= burst_i;
            if (!last_beat) begin
              count <= count + 1'b1;
            end
          end
        end
        WRITE: begin
          if (resp_i && !last_beat) begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          count <= '0;
        end
        default: begin
          count <= '0;
        end
      endcase
    end
  end

  // Request lines follow the state directly, so they rise the cycle after the
  // request is sampled and fall in DONE, right after the final beat.
  assign read_o    = (state == READ);
  assign write_o   = (state == WRITE);
  assign resp_o    = (state == DONE);
  assign address_o = addr_q;
  assign line_o    = buffer;
  assign burst_o   = buffer[s_burst*count +: s_burst];

endmodule : cacheline_adaptor

// File: tb/tb_cacheline_adaptor.sv
// ---------------------------------------------------------------------------
// tb_cacheline_adaptor
// Directed and randomized checks of cacheline_adaptor against a simple
// transaction-level model: a read line is the four beats in arrival order,
// a write line leaves as its four 64-bit words from the low end, memory sees
// the line-aligned address, and the cache sees exactly one resp_o per line.
// All interaction with the DUT happens on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int vectors     = 0;
  int miscompares = 0;

  logic [63:0]  beat_w [4];
  logic [255:0] last_read_line;

  always #5 clk = ~clk;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  // One comparison: counts it, and reports and counts a miscompare.
  task automatic check_output(input string tag, input logic [255:0] observed,
                              input logic [255:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [31:0] aligned(input logic [31:0] a);
    return a & 32'hFFFF_FFE0;
  endfunction

  // Cache-side noise during a burst; the adaptor must ignore all of it.
  task automatic scramble_cache_side();
    address_i = $urandom;
    line_i    = rand_line();
    read_i    = 1'($urandom_range(1, 0));
    write_i   = 1'($urandom_range(1, 0));
  endtask

  // Present a request for the next rising edge and move into the burst.
  task automatic apply_stimulus(input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [255:0] line);
    read_i    = rd;
    write_i   = wr;
    address_i = addr;
    line_i    = line;
    resp_i    = 1'b0;
    burst_i   = {$urandom, $urandom};
    tick();
  endtask

  // Feed beat_w[0..3] as a read burst with gaps in [gap_lo, gap_hi] before
  // each beat, then check the completion cycle and the assembled line.
  task automatic feed_read(input logic [31:0] addr, input int gap_lo,
                           input int gap_hi, input bit scramble);
    logic [255:0] exp_line;
    int gaps;
    exp_line = '0;
    for (int i = 0; i < 4; i++) begin
      gaps = $urandom_range(gap_hi, gap_lo);
      for (int g = 0; g < gaps; g++) begin
        if (scramble) scramble_cache_side();
        resp_i  = 1'b0;
        burst_i = {$urandom, $urandom};
        check_output("read_stall_read_o", read_o, 1'b1);
        check_output("read_stall_resp_o", resp_o, 1'b0);
        check_output("read_stall_addr", address_o, aligned(addr));
        tick();
      end
      if (scramble) scramble_cache_side();
      check_output("read_beat_read_o", read_o, 1'b1);
      check_output("read_beat_resp_o", resp_o, 1'b0);
      check_output("read_beat_addr", address_o, aligned(addr));
      resp_i  = 1'b1;
      burst_i = beat_w[i];
      exp_line[i*64 +: 64] = beat_w[i];
      tick();
    end
    resp_i  = 1'b0;
    read_i  = 1'b0;
    write_i = 1'b0;
    check_output("read_done_resp_o", resp_o, 1'b1);
    check_output("read_done_read_o", read_o, 1'b0);
    check_output("read_done_line_o", line_o, exp_line);
    last_read_line = exp_line;
    tick();
    check_output("read_after_resp_o", resp_o, 1'b0);
  endtask

  // Accept the four words of line as a write burst, checking each word on
  // burst_o before it is accepted, then check the completion cycle.
  task automatic feed_write(input logic [31:0] addr, input logic [255:0] line,
                            input int gap_lo, input int gap_hi, input bit scramble);
    int gaps;
    for (int i = 0; i < 4; i++) begin
      gaps = $urandom_range(gap_hi, gap_lo);
      for (int g = 0; g < gaps; g++) begin
        if (scramble) scramble_cache_side();
        resp_i = 1'b0;
        check_output("write_stall_write_o", write_o, 1'b1);
        check_output("write_stall_burst_o", burst_o, line[i*64 +: 64]);
        check_output("write_stall_addr", address_o, aligned(addr));
        tick();
      end
      if (scramble) scramble_cache_side();
      check_output("write_beat_write_o", write_o, 1'b1);
      check_output("write_beat_read_o", read_o, 1'b0);
      check_output("write_beat_resp_o", resp_o, 1'b0);
      check_output("write_beat_burst_o", burst_o, line[i*64 +: 64]);
      check_output("write_beat_addr", address_o, aligned(addr));
      resp_i  = 1'b1;
      burst_i = {$urandom, $urandom};
      tick();
    end
    resp_i  = 1'b0;
    read_i  = 1'b0;
    write_i = 1'b0;
    check_output("write_done_resp_o", resp_o, 1'b1);
    check_output("write_done_write_o", write_o, 1'b0);
    tick();
    check_output("write_after_resp_o", resp_o, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_read_o"}, read_o, 1'b0);
    check_output({tag, "_write_o"}, write_o, 1'b0);
    check_output({tag, "_resp_o"}, resp_o, 1'b0);
    check_output({tag, "_address_o"}, address_o, 32'h0);
    check_output({tag, "_line_o"}, line_o, 256'h0);
    check_output({tag, "_burst_o"}, burst_o, 64'h0);
  endtask

  initial begin
    logic [255:0] wline;
    logic [31:0]  addr;
    bit           do_write;

    // Reset held with a live read request and memory response.
    rst       = 1'b0;
    read_i    = 1'b1;
    write_i   = 1'b0;
    address_i = 32'h0000_1234;
    line_i    = rand_line();
    resp_i    = 1'b1;
    burst_i   = {$urandom, $urandom};
    repeat (3) tick();
    check_all_zero("reset");

    // Release: read_o only rises after read_i has been sampled.
    rst    = 1'b1;
    resp_i = 1'b0;
    #1;
    check_output("release_read_o_low", read_o, 1'b0);
    tick();
    check_output("release_read_o_high", read_o, 1'b1);
    beat_w[0] = 64'h1111_1111_1111_1111;
    beat_w[1] = 64'h2222_2222_2222_2222;
    beat_w[2] = 64'h3333_3333_3333_3333;
    beat_w[3] = 64'h4444_4444_4444_4444;
    check_output("read_addr_0x1220", address_o, 32'h0000_1220);
    feed_read(32'h0000_1234, 0, 0, 1'b0);
    check_output("read_line_const", last_read_line,
                 {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

    // Directed write of {D,C,B,A}.
    wline = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
             64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    apply_stimulus(1'b0, 1'b1, 32'h8000_0040, wline);
    check_output("write_first_beat_A", burst_o, 64'hAAAA_AAAA_AAAA_AAAA);
    feed_write(32'h8000_0040, wline, 0, 0, 1'b0);

    // Gapped read: two idle cycles before every beat.
    apply_stimulus(1'b1, 1'b0, 32'h0000_1234, rand_line());
    feed_read(32'h0000_1234, 2, 2, 1'b0);

    // Reset after two beats of a read: immediate abort, no response.
    apply_stimulus(1'b1, 1'b0, 32'h0000_2000, rand_line());
    resp_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      burst_i = {$urandom, $urandom};
      tick();
    end
    rst = 1'b0;
    #1;
    check_all_zero("midburst_reset");
    resp_i = 1'b0;
    read_i = 1'b0;
    tick();
    check_output("midburst_reset_no_resp", resp_o, 1'b0);
    rst = 1'b1;
    tick();
    check_output("post_reset_idle_read_o", read_o, 1'b0);
    check_output("post_reset_idle_resp_o", resp_o, 1'b0);
    for (int i = 0; i < 4; i++) beat_w[i] = {$urandom, $urandom};
    apply_stimulus(1'b1, 1'b0, 32'h0000_0100, rand_line());
    feed_read(32'h0000_0100, 0, 1, 1'b0);

    // Memory responses while idle must not move the adaptor.
    resp_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      burst_i = {$urandom, $urandom};
      tick();
      check_output("idle_resp_resp_o", resp_o, 1'b0);
      check_output("idle_resp_read_o", read_o, 1'b0);
      check_output("idle_resp_write_o", write_o, 1'b0);
      check_output("idle_resp_line_o", line_o, last_read_line);
    end

    // Read and write requested together: the write wins.
    wline = rand_line();
    apply_stimulus(1'b1, 1'b1, 32'h1234_5678, wline);
    check_output("rw_conflict_read_o", read_o, 1'b0);
    feed_write(32'h1234_5678, wline, 0, 1, 1'b0);

    // Random back-to-back traffic with stalls and cache-side noise.
    for (int t = 0; t < 24; t++) begin
      do_write = 1'($urandom_range(1, 0));
      addr     = $urandom;
      wline    = rand_line();
      if (do_write) begin
        apply_stimulus(1'($urandom_range(1, 0)), 1'b1, addr, wline);
        feed_write(addr, wline, 0, 2, 1'b1);
      end else begin
        for (int i = 0; i < 4; i++) beat_w[i] = {$urandom, $urandom};
        apply_stimulus(1'b1, 1'b0, addr, wline);
        feed_read(addr, 0, 2, 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_cacheline_adaptor
